mlp_layer_sequencer: RTL
========================

MLP_LAYER_SEQUENCER -- requirements
Module: mlp_layer_sequencer

Interface
REQ-001 SHALL have parameter N_INPUTS, default 3, meaning inputs per neuron including the bias at index 0.
REQ-002 SHALL have parameter IN_WIDTH, default 16, meaning bit-width of each input value.
REQ-003 SHALL have parameter BIAS_VAL, default 1, meaning the signed IN_WIDTH value presented at index 0.
REQ-004 SHALL have parameter MAC_LAT, default 1, meaning idle cycles between the last accumulate strobe and output_en.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port in_wr_en, input, 1, meaning input-buffer write strobe.
REQ-008 SHALL have port in_wr_addr, input, $clog2(N_INPUTS), meaning input-buffer write address; legal range 1..N_INPUTS-1.
REQ-009 SHALL have port in_wr_data, input, IN_WIDTH signed, meaning input-buffer write data.
REQ-010 SHALL have port in_wr_err, output, 1, meaning one-cycle pulse flagging a rejected write.
REQ-011 SHALL have port go, input, 1, meaning request one layer evaluation.
REQ-012 SHALL have port wgt_wr_active, input, 1, meaning the layer weight memories are being loaded.
REQ-013 SHALL have port busy, output, 1, meaning a sequence is in progress.
REQ-014 SHALL have port done, output, 1, meaning one-cycle pulse after output_en.
REQ-015 SHALL have port input_value, output, IN_WIDTH signed, meaning the value driven to the layer.
REQ-016 SHALL have port input_index, output, $clog2(N_INPUTS), meaning the weight read address driven to the layer.
REQ-017 SHALL have ports start, valid and output_en, outputs, 1 each, meaning the layer accumulator init, accumulate and output-capture strobes.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, DRAIN, OUTPUT, DONE.
REQ-019 SHALL accept go only in IDLE or DONE with wgt_wr_active=0; otherwise ignore go with no side effects.
REQ-020 After accepting go at edge E0, SHALL register busy=1 and input_index=0 at E0.
REQ-021 SHALL drive input_index=c after edge Ec, for c=0..N_INPUTS-1, then hold N_INPUTS-1.
REQ-022 SHALL drive input_value=element c after edge E(c+1), to match the layer's 1-cycle synchronous weight read; element 0 is BIAS_VAL.
REQ-023 SHALL assert start after E1 only, and valid after E2..E(N_INPUTS) only; start and valid are never high together.
REQ-024 SHALL hold start, valid and output_en low for MAC_LAT cycles (DRAIN) after the last valid.
REQ-025 SHALL assert output_en for exactly one cycle (OUTPUT) after DRAIN.
REQ-026 SHALL assert done for exactly one cycle (DONE) after OUTPUT, with busy=0 in that cycle.
REQ-027 SHALL leave IDLE-equivalent behaviour in DONE, so a go in the DONE cycle starts a back-to-back sequence.
REQ-028 SHALL write in_wr_data to buffer[in_wr_addr] when in_wr_en=1, busy=0 and in_wr_addr is in 1..N_INPUTS-1.
REQ-029 SHALL drop any other write and pulse in_wr_err for one cycle (addr 0, addr >= N_INPUTS, or busy=1).
REQ-030 SHALL sample input_value combinationally from the buffer only through registered outputs; all ports are registered.
REQ-031 SHALL not interrupt a running sequence when wgt_wr_active rises; it is checked at go acceptance only.
REQ-032 SHALL complete a full sequence go->done in N_INPUTS+MAC_LAT+3 edges.

Reset
REQ-033 SHALL, on rst_n low, immediately (asynchronously) force IDLE and clear all outputs, the counter and all buffer entries to 0.
REQ-034 SHALL, on reset mid-sequence, leave no strobe pending after release; the next sequence requires a new go.

Structure
REQ-035 SHALL take the FSM state encoding and MAC_LAT default from the shared package mlp_pkg.
REQ-036 SHALL place the input buffer and its write-protection logic in a sub-module mlp_input_buffer.

Verification
REQ-037 With N_INPUTS=3, MAC_LAT=1, buffer {BIAS,5,-3}, go -> index 0,1,2; start with value 1 at cycle 1; valid with 5 then -3; output_en at cycle 5; done at cycle 6.
REQ-038 Write to addr 0 or 3, or write while busy -> in_wr_err pulse and buffer unchanged.
REQ-039 go with wgt_wr_active=1 -> no strobes and busy stays 0; the same go with wgt_wr_active=0 -> normal sequence.
REQ-040 go in the DONE cycle -> the second sequence starts at the next edge with no gap cycles and identical strobe timing.
REQ-041 rst_n low during ISSUE -> outputs 0 at once, state IDLE; after release, no output_en until a new go.
REQ-042 When driving a real layer instance with weights {1,2,3}, inputs {1,5,-3}: 1*1+5*2+(-3)*3=2 -> layer output 2 after done.

Source files
------------

// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared state encoding and defaults for the MLP layer sequencer
package mlp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_OUTPUT = 3'd3,
    ST_DONE   = 3'd4
  } mlp_state_t;

  localparam int MLP_MAC_LAT_DEFAULT = 1;

endpackage

// File: rtl/mlp_input_buffer.sv
// rtl/mlp_input_buffer.sv - neuron input buffer with write protection; index 0 reads the bias
module mlp_input_buffer #(
  parameter int N_INPUTS = 3,
  parameter int IN_WIDTH = 16,
  parameter int BIAS_VAL = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(N_INPUTS)-1:0]   wr_addr,
  input  logic signed [IN_WIDTH-1:0]    wr_data,
  input  logic                          busy,
  output logic                          wr_err,
  input  logic [$clog2(N_INPUTS)-1:0]   rd_addr,
  output logic signed [IN_WIDTH-1:0]    rd_data
);

  localparam logic signed [IN_WIDTH-1:0] BIAS_W = IN_WIDTH'(BIAS_VAL);

  logic signed [IN_WIDTH-1:0] mem [1:N_INPUTS-1];
  logic                       addr_ok;

  // Slot 0 is the hard-wired bias and is never writable.
  assign addr_ok = (wr_addr != '0) && (int'(wr_addr) < N_INPUTS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < N_INPUTS; i++) mem[i] <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && (busy || !addr_ok);
      if (wr_en && !busy && addr_ok) mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = BIAS_W;
    if (rd_addr != '0 && int'(rd_addr) < N_INPUTS) rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// rtl/mlp_layer_sequencer.sv - steps one neuron's inputs into a layer and strobes init/accumulate/capture
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int N_INPUTS = 3,
  parameter int IN_WIDTH = 16,
  parameter int BIAS_VAL = 1,
  parameter int MAC_LAT  = MLP_MAC_LAT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_wr_en,
  input  logic [$clog2(N_INPUTS)-1:0]   in_wr_addr,
  input  logic signed [IN_WIDTH-1:0]    in_wr_data,
  output logic                          in_wr_err,
  input  logic                          go,
  input  logic                          wgt_wr_active,
  output logic                          busy,
  output logic                          done,
  output logic signed [IN_WIDTH-1:0]    input_value,
  output logic [$clog2(N_INPUTS)-1:0]   input_index,
  output logic                          start,
  output logic                          valid,
  output logic                          output_en
);

  localparam int              AW        = $clog2(N_INPUTS);
  localparam int              CW        = $clog2(MAC_LAT + 2);
  localparam logic [AW-1:0]   LAST_IDX  = AW'(N_INPUTS - 1);
  localparam logic [CW-1:0]   DRAIN_END = CW'(MAC_LAT);

  mlp_state_t                 state, state_nxt;
  logic [CW-1:0]              cnt, cnt_nxt;
  logic                       busy_nxt, start_nxt, valid_nxt, oen_nxt, done_nxt;
  logic [AW-1:0]              idx_nxt;
  logic signed [IN_WIDTH-1:0] val_nxt, rd_data;

  mlp_input_buffer #(
    .N_INPUTS (N_INPUTS),
    .IN_WIDTH (IN_WIDTH),
    .BIAS_VAL (BIAS_VAL)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_wr_en),
    .wr_addr (in_wr_addr),
    .wr_data (in_wr_data),
    .busy    (busy),
    .wr_err  (in_wr_err),
    .rd_addr (input_index),
    .rd_data (rd_data)
  );

  // input_index leads input_value by one cycle to line up with the layer's registered weight read.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    idx_nxt   = input_index;
    val_nxt   = input_value;
    start_nxt = 1'b0;
    valid_nxt = 1'b0;
    oen_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (go && !wgt_wr_active) begin
          state_nxt = ST_ISSUE;
          busy_nxt  = 1'b1;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      ST_ISSUE: begin
        val_nxt   = rd_data;
        start_nxt = (input_index == '0);
        valid_nxt = (input_index != '0);
        if (input_index == LAST_IDX) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = '0;
        end else begin
          idx_nxt = input_index + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt == DRAIN_END) begin
          state_nxt = ST_OUTPUT;
          oen_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_OUTPUT: begin
        state_nxt = ST_DONE;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      input_index <= '0;
      input_value <= '0;
      start       <= 1'b0;
      valid       <= 1'b0;
      output_en   <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      busy        <= busy_nxt;
      input_index <= idx_nxt;
      input_value <= val_nxt;
      start       <= start_nxt;
      valid       <= valid_nxt;
      output_en   <= oen_nxt;
      done        <= done_nxt;
    end
  end

endmodule
